snn_weight_loader: RTL and testbench
====================================

# snn_weight_loader

Host-side programming engine for the SNN weight memory. It accepts a byte stream of DEPTH weight bytes followed by one checksum byte, and drives the memory port (address, write-enable, write data) to store them at consecutive addresses. It then reads every location back and reports pass or fail. It sits between the chip input pins and the weight memory, acting as the initiator/writer for the memory's registered-read port.

## Interface
- DEPTH, 16: number of weight locations written and verified.
- AW, 4: address width; DEPTH ≤ 2^AW.
- DW, 8: data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
- load_valid  in  1  stream byte available.
- load_data  in  DW  stream byte.
- load_ready  out  1  loader accepts the byte this cycle; a transfer is load_valid & load_ready at a rising edge.
- mem_addr  out  AW  memory address, registered.
- mem_we  out  1  memory write enable, registered, active-high.
- mem_wdata  out  DW  memory write data, registered.
- mem_rdata  in  DW  memory read data; the memory registers it one edge after sampling mem_addr with mem_we=0.
- busy  out  1  high in WRITE, CHECK and VERIFY.
- done  out  1  high in DONE; held until the next start.
- err  out  2  result code: 00 pass, 01 stream checksum bad, 10 readback mismatch; valid while done=1.

## Operation
- States: IDLE, WRITE, CHECK, VERIFY, DONE.
- Reset value of every output is 0. The reset state is IDLE, and all internal counters and sums are cleared.
- **IDLE / DONE**
  - start=1 → WRITE.
  - On that transition: wr_cnt=0, wsum=0, done=0, err=00.
- **WRITE**
  - load_ready = 1.
  - Each transfer: mem_addr←wr_cnt, mem_wdata←load_data, mem_we←1, wsum←wsum+load_data (mod 2^DW), wr_cnt++.
  - Edge without a transfer: mem_we←0. mem_addr and mem_wdata hold.
  - Transfer with wr_cnt=DEPTH-1 → CHECK.
- **CHECK**
  - load_ready = 1; mem_we←0.
  - On transfer: if (wsum+load_data) mod 2^DW ≠ 0 → err←01, DONE. Otherwise → VERIFY with rd_cnt=0, cap_cnt=0, rsum=0.
- **VERIFY**
  - load_ready = 0; mem_we = 0.
  - Each edge while rd_cnt<DEPTH: mem_addr←rd_cnt, rd_cnt++.
  - The read byte for an address is sampled two edges after the edge that drove that address. Each sample: rsum←rsum+mem_rdata, cap_cnt++.
  - The edge capturing sample DEPTH-1 compares the final rsum with wsum:
    - equal → err←00.
    - not equal → err←10.
    - Either way → DONE.
- **DONE**
  - done=1, busy=0.
  - mem_addr holds; mem_we=0.
- start outside IDLE/DONE is ignored. load_valid outside WRITE/CHECK is ignored.
- Reset mid-operation returns to IDLE immediately and drops mem_we. Memory contents after a partial load are unspecified.
- Arithmetic: all sums are modulo 2^DW. Counters are AW+1 bits, so DEPTH=2^AW does not wrap early.

## Timing
- Edge numbering: edge 0 samples start.
- Zero-stall load:
  - Data transfers on edges 1..DEPTH.
  - Checksum transfer on edge DEPTH+1.
  - Read addresses driven on edges DEPTH+2..2·DEPTH+1.
  - Captures on edges DEPTH+4..2·DEPTH+3.
  - done is visible after edge 2·DEPTH+3 (edge 35 for DEPTH=16).
- The mem_we pulse for the last data byte appears in the first CHECK cycle; this is intended.
- Stalls (load_valid=0) extend WRITE/CHECK cycle-for-cycle. There is no timeout.
- load_ready is combinational from state only; it never depends on load_valid.
- done and err change only on the DONE-entry edge and on the start edge.

## Test plan
- **Pass, zero stall:** reset; start; stream bytes 0x01..0x10 then checksum 0x78 with load_valid held high → 16 mem_we pulses to addresses 0..15 with data 0x01..0x10; done=1 after edge 35; err=00.
- **Bad stream checksum:** same 16 bytes, checksum 0x00 → DONE right after the checksum edge; err=01; no VERIFY reads issued.
- **Readback mismatch:** memory model corrupts address 7 (bit 0 flipped) → err=10; done=1.
- **Stalls:** load_valid toggled 1/0 every cycle with random bytes plus correct checksum → writes only on transfer edges; err=00; total latency extended by 17 cycles.
- **Reset mid-load:** assert rst_n=0 after 5 transfers → all outputs 0, state IDLE; a new start then completes a clean pass.
- **Ignored and repeated start:** start pulsed during VERIFY → no effect; start in DONE → done and err clear, new load begins.

Source files
------------

// File: rtl/snn_weight_loader.sv
// snn_weight_loader: streams DEPTH weight bytes plus a checksum byte into the
// SNN weight memory, then reads every location back and reports the result.
module snn_weight_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err
);

    // Counters carry one extra bit so DEPTH = 2^AW is representable.
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] ERR_PASS = 2'b00;
    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_RB   = 2'b10;

    typedef enum logic [2:0] {IDLE, WRITE, CHECK, VERIFY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] cap_cnt;
    logic [DW-1:0] wsum;
    logic [DW-1:0] rsum;
    logic          vld_p0;
    logic          vld_p1;
    logic          xfer;

    // All checksums wrap modulo 2^DW.
    function automatic logic [DW-1:0] add_mod(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        return a + b;
    endfunction

    assign load_ready = (state == WRITE) || (state == CHECK);
    assign busy       = (state == WRITE) || (state == CHECK) || (state == VERIFY);
    assign xfer       = load_valid & load_ready;

    // Load/verify sequencer with registered memory port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            cap_cnt   <= '0;
            wsum      <= '0;
            rsum      <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= ERR_PASS;
        end else begin
            case (state)
                IDLE, DONE: begin
                    mem_we <= 1'b0;
                    vld_p0 <= 1'b0;
                    vld_p1 <= 1'b0;
                    if (start) begin
                        state  <= WRITE;
                        wr_cnt <= '0;
                        wsum   <= '0;
                        done   <= 1'b0;
                        err    <= ERR_PASS;
                    end
                end
                WRITE: begin
                    if (xfer) begin
                        mem_addr  <= wr_cnt[AW-1:0];
                        mem_wdata <= load_data;
                        mem_we    <= 1'b1;
                        wsum      <= add_mod(wsum, load_data);
                        wr_cnt    <= wr_cnt + CNT_ONE;
                        if (wr_cnt == LAST_IDX) begin
                            state <= CHECK;
                        end
                    end else begin
                        mem_we <= 1'b0;
                    end
                end
                CHECK: begin
                    mem_we <= 1'b0;
                    if (xfer) begin
                        if (add_mod(wsum, load_data) != '0) begin
                            err   <= ERR_CHK;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state   <= VERIFY;
                            rd_cnt  <= '0;
                            cap_cnt <= '0;
                            rsum    <= '0;
                            vld_p0  <= 1'b0;
                            vld_p1  <= 1'b0;
                        end
                    end
                end
                VERIFY: begin
                    mem_we <= 1'b0;
                    // p0: address issued to memory this edge
                    if (rd_cnt < DEPTH_C) begin
                        mem_addr <= rd_cnt[AW-1:0];
                        rd_cnt   <= rd_cnt + CNT_ONE;
                        vld_p0   <= 1'b1;
                    end else begin
                        vld_p0 <= 1'b0;
                    end
                    // p1: memory has sampled the address, data lands next edge
                    vld_p1 <= vld_p0;
                    // p2: read byte captured and accumulated
                    if (vld_p1) begin
                        rsum    <= add_mod(rsum, mem_rdata);
                        cap_cnt <= cap_cnt + CNT_ONE;
                        if (cap_cnt == LAST_IDX) begin
                            err   <= (add_mod(rsum, mem_rdata) == wsum) ? ERR_PASS : ERR_RB;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_weight_loader.sv
// Bench for snn_weight_loader: behavioural weight memory, random byte streams
// and a sum-based reference model of the expected result code and latency.
module tb_snn_weight_loader;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_ready;
    logic [3:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy;
    logic       done;
    logic [1:0] err;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [DEPTH];
    logic [7:0] stream [DEPTH+1];
    bit         corrupt = 1'b0;

    int         done_edge;
    int         verify_cycles;
    bit         writes_ok;
    logic       done_after_start;
    logic [1:0] err_after_start;
    logic       busy_after_start;

    snn_weight_loader #(.DEPTH(DEPTH), .AW(4), .DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    end

    // Weight memory: write port, registered read, optional bit-0 fault at address 7.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr] ^ ((corrupt && mem_addr == 4'd7) ? 8'h01 : 8'h00);
    end

    // Expected result code from the stream contents and the memory fault.
    function automatic logic [1:0] exp_err();
        logic [7:0] ws;
        logic [7:0] rs;
        ws = 8'h00;
        rs = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            ws = ws + stream[i];
            rs = rs + (stream[i] ^ ((corrupt && i == 7) ? 8'h01 : 8'h00));
        end
        if (8'(ws + stream[DEPTH]) != 8'h00) return 2'b01;
        if (rs != ws) return 2'b10;
        return 2'b00;
    endfunction

    task automatic set_counting_stream(input logic [7:0] chk);
        for (int i = 0; i < DEPTH; i++) stream[i] = 8'(i + 1);
        stream[DEPTH] = chk;
    endtask

    task automatic set_random_stream();
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            stream[i] = 8'($urandom);
            s = s + stream[i];
        end
        stream[DEPTH] = 8'(0 - s);
    endtask

    // Runs one load: start on edge 0, stream with optional 0/1 stall pattern,
    // optional start pulse at a given edge, observe until done (bounded).
    task automatic run_load(input bit stall, input int pulse_edge);
        int   e;
        int   idx;
        int   wr_n;
        bit   tog;
        bit   bad;
        logic v;
        done_edge     = -1;
        verify_cycles = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_after_start = done;
        err_after_start  = err;
        busy_after_start = busy;
        e = 0; idx = 0; wr_n = 0; tog = 1'b0; bad = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (mem_we) begin
                if (wr_n >= DEPTH || mem_addr != 4'(wr_n) || mem_wdata != stream[wr_n]) bad = 1'b1;
                wr_n++;
            end
            if (busy && !load_ready) verify_cycles++;
            if (done) begin
                done_edge = e;
                break;
            end
            start = (e == pulse_edge);
            if (idx <= DEPTH) begin
                v = stall ? tog : 1'b1;
                tog = !tog;
                load_valid = v;
                load_data  = v ? stream[idx] : 8'($urandom);
                if (v && load_ready) idx++;
            end else begin
                load_valid = 1'b0;
            end
            @(negedge clk);
            e++;
        end
        start      = 1'b0;
        load_valid = 1'b0;
        writes_ok  = !bad && (wr_n == DEPTH);
    endtask

    task automatic test_reset();
        tests++;
        if ({mem_addr, mem_we, mem_wdata, busy, done, err, load_ready} !== 19'h0) begin
            fails++;
            $display("FAIL reset_outputs: got addr=%0h we=%0b wdata=%0h busy=%0b done=%0b err=%0b ready=%0b, want all 0",
                     mem_addr, mem_we, mem_wdata, busy, done, err, load_ready);
        end
    endtask

    task automatic test_pass_zero_stall();
        logic [1:0] ee;
        corrupt = 1'b0;
        set_counting_stream(8'h78);
        ee = exp_err();
        run_load(1'b0, -1);
        tests++;
        if (done_edge !== 2*DEPTH+3) begin
            fails++; $display("FAIL pass_latency: done at edge %0d, want %0d", done_edge, 2*DEPTH+3);
        end
        tests++;
        if (err !== ee) begin
            fails++; $display("FAIL pass_err: got %b want %b", err, ee);
        end
        tests++;
        if (writes_ok !== 1'b1) begin
            fails++; $display("FAIL pass_writes: write sequence wrong (got ok=%0b want 1)", writes_ok);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL pass_busy_done: busy=%0b want 0", busy);
        end
    endtask

    task automatic test_bad_checksum();
        logic [1:0] ee;
        corrupt = 1'b0;
        set_counting_stream(8'h00);
        ee = exp_err();
        run_load(1'b0, -1);
        tests++;
        if (done_edge !== DEPTH+1) begin
            fails++; $display("FAIL badchk_latency: done at edge %0d, want %0d", done_edge, DEPTH+1);
        end
        tests++;
        if (err !== ee) begin
            fails++; $display("FAIL badchk_err: got %b want %b", err, ee);
        end
        tests++;
        if (verify_cycles !== 0) begin
            fails++; $display("FAIL badchk_no_verify: %0d verify cycles, want 0", verify_cycles);
        end
    endtask

    task automatic test_mismatch();
        logic [1:0] ee;
        corrupt = 1'b1;
        set_random_stream();
        ee = exp_err();
        run_load(1'b0, -1);
        corrupt = 1'b0;
        tests++;
        if (err !== ee || ee !== 2'b10) begin
            fails++; $display("FAIL mismatch_err: got %b want %b", err, ee);
        end
        tests++;
        if (done_edge !== 2*DEPTH+3) begin
            fails++; $display("FAIL mismatch_done: done at edge %0d, want %0d", done_edge, 2*DEPTH+3);
        end
    endtask

    task automatic test_stalls();
        logic [1:0] ee;
        corrupt = 1'b0;
        set_random_stream();
        ee = exp_err();
        run_load(1'b1, -1);
        tests++;
        if (done_edge !== 2*DEPTH+3+DEPTH+1) begin
            fails++; $display("FAIL stall_latency: done at edge %0d, want %0d", done_edge, 2*DEPTH+3+DEPTH+1);
        end
        tests++;
        if (err !== ee) begin
            fails++; $display("FAIL stall_err: got %b want %b", err, ee);
        end
        tests++;
        if (writes_ok !== 1'b1) begin
            fails++; $display("FAIL stall_writes: write sequence wrong (got ok=%0b want 1)", writes_ok);
        end
    endtask

    task automatic test_reset_mid_load();
        corrupt = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 8'($urandom);
            @(negedge clk);
        end
        load_valid = 1'b0;
        tests++;
        if (mem_we !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL midreset_pre: we=%0b busy=%0b, want 1 1", mem_we, busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({mem_addr, mem_we, mem_wdata, busy, done, err, load_ready} !== 19'h0) begin
            fails++;
            $display("FAIL midreset_outputs: got addr=%0h we=%0b wdata=%0h busy=%0b done=%0b err=%0b ready=%0b, want all 0",
                     mem_addr, mem_we, mem_wdata, busy, done, err, load_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_random_stream();
        run_load(1'b0, -1);
        tests++;
        if (done_edge !== 2*DEPTH+3 || err !== 2'b00) begin
            fails++; $display("FAIL midreset_reload: done edge %0d err %b, want %0d 00", done_edge, err, 2*DEPTH+3);
        end
        tests++;
        if (writes_ok !== 1'b1) begin
            fails++; $display("FAIL midreset_writes: write sequence wrong (got ok=%0b want 1)", writes_ok);
        end
    endtask

    task automatic test_start_ignored_and_restart();
        corrupt = 1'b0;
        set_random_stream();
        run_load(1'b0, DEPTH + 9);
        tests++;
        if (done_edge !== 2*DEPTH+3 || err !== 2'b00) begin
            fails++; $display("FAIL verify_start_ignored: done edge %0d err %b, want %0d 00", done_edge, err, 2*DEPTH+3);
        end
        set_counting_stream(8'h00);
        run_load(1'b0, -1);
        tests++;
        if (err !== 2'b01) begin
            fails++; $display("FAIL restart_prep_err: got %b want 01", err);
        end
        set_random_stream();
        run_load(1'b0, -1);
        tests++;
        if (done_after_start !== 1'b0 || err_after_start !== 2'b00 || busy_after_start !== 1'b1) begin
            fails++; $display("FAIL restart_clear: done=%0b err=%b busy=%0b after start, want 0 00 1",
                              done_after_start, err_after_start, busy_after_start);
        end
        tests++;
        if (done_edge !== 2*DEPTH+3 || err !== exp_err()) begin
            fails++; $display("FAIL restart_result: done edge %0d err %b, want %0d %b", done_edge, err, 2*DEPTH+3, exp_err());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_pass_zero_stall();
        test_bad_checksum();
        test_mismatch();
        test_stalls();
        test_reset_mid_load();
        test_start_ignored_and_restart();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
